// File: rtl/mul_functional_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_functional_unit_pkg
// Shared definitions for the MUL functional unit of the Tomasulo datapath:
//   - DEF_DATA_W / DEF_TAG_W : default operand and tag widths
//   - TAG_W/TAG_X/TAG_Y/TAG_Z : MUL reservation-station row tags (w/x/y/z)
//   - SANITY                  : operand value the reservation station drives
//                               while it has nothing to issue
//   - mul_fu_state_t          : functional-unit FSM state encoding
// Note: the row tag constant TAG_W shares its name with the TAG_W width
// parameter of the unit; inside the unit the parameter wins, so the width
// default is exported here as DEF_TAG_W.
// -----------------------------------------------------------------------------
package mul_functional_unit_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_TAG_W  = 3;

    // MUL rows carry the tag MSB set so they never alias the all-zero reset tag
    localparam logic [DEF_TAG_W-1:0] TAG_W = 3'd4;
    localparam logic [DEF_TAG_W-1:0] TAG_X = 3'd5;
    localparam logic [DEF_TAG_W-1:0] TAG_Y = 3'd6;
    localparam logic [DEF_TAG_W-1:0] TAG_Z = 3'd7;

    localparam logic [DEF_DATA_W-1:0] SANITY = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } mul_fu_state_t;

endpackage : mul_functional_unit_pkg

// File: rtl/mul_functional_unit_shift_add_core.sv
// -----------------------------------------------------------------------------
// shift_add_core
// Iterative shift-add datapath: 2*DATA_W accumulator, multiplicand/multiplier
// shift registers and step counter. One partial product per cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : load operands, clear accumulator, counter = DATA_W-1
//   a_i, b_i    : multiplicand, multiplier
//   done_o      : high during the final step (counter at 0)
//   product_o   : accumulator including the current step's partial product;
//                 equals the full product while done_o is high
// -----------------------------------------------------------------------------
module shift_add_core
    import mul_functional_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q, run_d;
    logic [2*DATA_W-1:0] acc_sum_s;

    // Partial-product add for the current step and completion detect
    always_comb begin
        acc_sum_s = acc_q;
        if (mplier_q[0]) begin
            acc_sum_s = acc_q + mcand_q;
        end else begin
            acc_sum_s = acc_q;
        end
        product_o = acc_sum_s;
        done_o    = run_q && (cnt_q == {CNT_W{1'b0}});
    end

    // Next-state: load on start, one shift-add step per cycle while running
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start_i) begin
            acc_d    = {(2*DATA_W){1'b0}};
            mcand_d  = {{DATA_W{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = CNT_W'(DATA_W - 1);
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            run_d    = (cnt_q != {CNT_W{1'b0}});
        end else begin
            run_d    = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {(2*DATA_W){1'b0}};
            mcand_q  <= {(2*DATA_W){1'b0}};
            mplier_q <= {DATA_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule : shift_add_core

// File: rtl/mul_functional_unit.sv
// -----------------------------------------------------------------------------
// mul_functional_unit
// Iterative DATA_W x DATA_W multiplier fed by the MUL reservation station.
// Accepts an operand pair + tag in IDLE, runs DATA_W shift-add cycles, then
// requests the CDB and holds result/tag until granted.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_valid/op_a/op_b/op_tag : issue request (ignored, and flagged, while busy)
//   busy                : MUL_Status back to the reservation station
//   cdb_req / cdb_grant : CDB handshake (grant only acted on in DONE)
//   cdb_result/cdb_tag  : product and producing tag, qualify with cdb_req
//   ovf                 : product did not fit in DATA_W bits
//   protocol_err        : sticky, issue attempted while busy
// Build option: define MUL_FU_SAT_EN to saturate cdb_result to all ones on
// overflow; otherwise the result is the truncated low DATA_W bits.
// -----------------------------------------------------------------------------
module mul_functional_unit #(
    parameter int DATA_W = mul_functional_unit_pkg::DEF_DATA_W,
    parameter int TAG_W  = mul_functional_unit_pkg::DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [TAG_W-1:0]  op_tag,
    output logic              busy,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [DATA_W-1:0] cdb_result,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic              ovf,
    output logic              protocol_err
);

    import mul_functional_unit_pkg::*;

    mul_fu_state_t       state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                busy_q, busy_d;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [TAG_W-1:0]    ctag_q, ctag_d;
    logic                ovf_q, ovf_d;
    logic                perr_q, perr_d;

    logic                start_s;
    logic                core_done_s;
    logic [2*DATA_W-1:0] core_prod_s;
    logic                prod_ovf_s;
    logic [DATA_W-1:0]   result_sel_s;

    shift_add_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_s),
        .a_i       (op_a),
        .b_i       (op_b),
        .done_o    (core_done_s),
        .product_o (core_prod_s)
    );

    // Overflow detect and result selection (saturating or truncating build)
    always_comb begin
        prod_ovf_s = (core_prod_s[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
`ifdef MUL_FU_SAT_EN
        if (prod_ovf_s) begin
            result_sel_s = {DATA_W{1'b1}};
        end else begin
            result_sel_s = core_prod_s[DATA_W-1:0];
        end
`else
        result_sel_s = core_prod_s[DATA_W-1:0];
`endif
    end

    // FSM next-state, CDB capture and sticky protocol error
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        result_d = result_q;
        ctag_d   = ctag_q;
        ovf_d    = ovf_q;
        start_s  = 1'b0;
        // busy_q is 0 in IDLE, so a legal issue never sets the flag
        perr_d   = perr_q | (op_valid & busy_q);
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    start_s = 1'b1;
                    tag_d   = op_tag;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (core_done_s) begin
                    result_d = result_sel_s;
                    ctag_d   = tag_q;
                    ovf_d    = prod_ovf_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (cdb_grant) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        req_d  = (state_d == ST_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tag_q    <= {TAG_W{1'b0}};
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            result_q <= {DATA_W{1'b0}};
            ctag_q   <= {TAG_W{1'b0}};
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            result_q <= result_d;
            ctag_q   <= ctag_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
        end
    end

    assign busy         = busy_q;
    assign cdb_req      = req_q;
    assign cdb_result   = result_q;
    assign cdb_tag      = ctag_q;
    assign ovf          = ovf_q;
    assign protocol_err = perr_q;

endmodule : mul_functional_unit
